// File: rtl/rr_timeout_arbiter.sv
// rr_timeout_arbiter: round-robin crossbar arbiter with a
// per-port hold timeout loaded from header flit lengths.
module rr_timeout_arbiter #(
    parameter int NPORTS     = 5,
    parameter int LEN_W      = 12,
    parameter int FLIT_ID_W  = 3,
    parameter int HEADER_ID  = 1,
    parameter int TIMEOUT_EN = 1,
    localparam int IDX_W =
        (NPORTS > 1) ? $clog2(NPORTS) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NPORTS-1:0]           req,
    input  logic [NPORTS*FLIT_ID_W-1:0] flit_id,
    input  logic [NPORTS*LEN_W-1:0]     length,
    output logic [NPORTS-1:0]           grant,
    output logic                        grant_valid,
    output logic [IDX_W-1:0]            grant_idx,
    output logic [NPORTS-1:0]           timeout_evt
);

    logic              own_q, own_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [NPORTS-1:0] evt_q, evt_d;
    logic [NPORTS-1:0] expired;

    logic              own_exp;
    logic              hold;
    logic              found;
    logic [IDX_W-1:0]  pick;
    logic [IDX_W:0]    cand;

    if (TIMEOUT_EN != 0) begin : g_to
        localparam int CMP_W = LEN_W + 1;
        localparam logic [LEN_W-1:0] CNT_MAX = '1;

        logic [LEN_W-1:0] limit_q [NPORTS];
        logic [LEN_W-1:0] count_q [NPORTS];

        // Latch the hold limit from every header flit.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int i = 0; i < NPORTS; i++)
                    limit_q[i] <= '0;
            end else begin
                for (int i = 0; i < NPORTS; i++)
                    if (flit_id[i*FLIT_ID_W +: FLIT_ID_W]
                        == FLIT_ID_W'(HEADER_ID))
                        limit_q[i] <= length[i*LEN_W +: LEN_W];
            end
        end

        // Count granted cycles, saturating; clear when not granted.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int i = 0; i < NPORTS; i++)
                    count_q[i] <= '0;
            end else begin
                for (int i = 0; i < NPORTS; i++)
                    if (!grant[i])
                        count_q[i] <= '0;
                    else if (count_q[i] != CNT_MAX)
                        count_q[i] <= count_q[i] + LEN_W'(1);
            end
        end

        // Owner expires on the cycle that reaches its limit.
        always_comb begin
            expired = '0;
            for (int i = 0; i < NPORTS; i++)
                expired[i] = grant[i]
                    && (limit_q[i] != '0)
                    && ((CMP_W'(count_q[i]) + CMP_W'(1))
                        >= CMP_W'(limit_q[i]));
        end
    end else begin : g_no_to
        assign expired = '0;
    end

    // State register: owner, last-owner pointer, timeout pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            own_q <= 1'b0;
            idx_q <= '0;
            ptr_q <= IDX_W'(NPORTS - 1);
            evt_q <= '0;
        end else begin
            own_q <= own_d;
            idx_q <= idx_d;
            ptr_q <= ptr_d;
            evt_q <= evt_d;
        end
    end

    // Next state: hold the owner or search from ptr_q+1.
    always_comb begin
        own_exp = own_q && expired[idx_q];
        hold    = own_q && req[idx_q] && !own_exp;
        found   = 1'b0;
        pick    = '0;
        cand    = '0;
        for (int k = 1; k <= NPORTS; k++) begin
            cand = {1'b0, ptr_q} + (IDX_W+1)'(k);
            if (cand >= (IDX_W+1)'(NPORTS))
                cand = cand - (IDX_W+1)'(NPORTS);
            if (!found && req[cand[IDX_W-1:0]]
                && !(own_exp
                     && cand[IDX_W-1:0] == idx_q)) begin
                found = 1'b1;
                pick  = cand[IDX_W-1:0];
            end
        end
        own_d = own_q;
        idx_d = idx_q;
        ptr_d = ptr_q;
        evt_d = '0;
        if (!hold) begin
            if (own_exp)
                evt_d = NPORTS'(1) << idx_q;
            own_d = found;
            idx_d = found ? pick : '0;
            ptr_d = found ? pick : ptr_q;
        end
    end

    // Outputs decoded from registered state only.
    always_comb begin
        grant = '0;
        if (own_q)
            grant[idx_q] = 1'b1;
        grant_valid = own_q;
        grant_idx   = idx_q;
        timeout_evt = evt_q;
    end

endmodule

// File: tb/tb_rr_timeout_arbiter.sv
// tb_rr_timeout_arbiter: scenario tasks plus random traffic
// checked against a cycle-level reference model.
module tb_rr_timeout_arbiter;

    localparam int NP  = 5;
    localparam int LW  = 12;
    localparam int FW  = 3;
    localparam int HID = 1;

    logic            clk = 1'b0;
    logic            rst;
    logic [NP-1:0]   req;
    logic [NP*FW-1:0] flit_id;
    logic [NP*LW-1:0] length;
    logic [NP-1:0]   grant;
    logic            grant_valid;
    logic [2:0]      grant_idx;
    logic [NP-1:0]   timeout_evt;

    logic [NP-1:0]   req4;
    logic [NP*FW-1:0] flit4;
    logic [NP*4-1:0] len4;
    logic [NP-1:0]   grant4;
    logic            gv4;
    logic [2:0]      gi4;
    logic [NP-1:0]   evt4;

    int n_chk  = 0;
    int n_fail = 0;

    int m_own, m_cnt, m_ptr, m_evt;
    int m_lim [NP];

    always #5 clk = ~clk;

    rr_timeout_arbiter u_dut (
        .clk(clk), .rst(rst), .req(req),
        .flit_id(flit_id), .length(length),
        .grant(grant), .grant_valid(grant_valid),
        .grant_idx(grant_idx),
        .timeout_evt(timeout_evt)
    );

    rr_timeout_arbiter #(.LEN_W(4)) u_dut4 (
        .clk(clk), .rst(rst), .req(req4),
        .flit_id(flit4), .length(len4),
        .grant(grant4), .grant_valid(gv4),
        .grant_idx(gi4), .timeout_evt(evt4)
    );

    task automatic model_reset();
        m_own = -1;
        m_cnt = 0;
        m_ptr = NP - 1;
        m_evt = -1;
        for (int i = 0; i < NP; i++) m_lim[i] = 0;
    endtask

    task automatic model_step();
        bit exp_c;
        bit hold;
        int nxt;
        int p;
        exp_c = 1'b0;
        hold  = 1'b0;
        if (m_own >= 0) begin
            exp_c = (m_lim[m_own] != 0)
                && (m_cnt + 1 >= m_lim[m_own]);
            hold = req[m_own] && !exp_c;
        end
        m_evt = -1;
        if (hold) begin
            m_cnt++;
        end else begin
            if (exp_c) m_evt = m_own;
            nxt = -1;
            for (int k = 1; k <= NP; k++) begin
                p = (m_ptr + k) % NP;
                if (nxt < 0 && req[p]
                    && !(exp_c && p == m_own))
                    nxt = p;
            end
            if (nxt >= 0) m_ptr = nxt;
            m_own = nxt;
            m_cnt = 0;
        end
        for (int i = 0; i < NP; i++)
            if (flit_id[i*FW +: FW] == FW'(HID))
                m_lim[i] = int'(length[i*LW +: LW]);
    endtask

    function automatic logic [13:0] mvec();
        logic [4:0] g;
        logic [4:0] e;
        logic [2:0] ix;
        g  = (m_own >= 0) ? (5'd1 << m_own) : 5'd0;
        ix = (m_own >= 0) ? 3'(m_own) : 3'd0;
        e  = (m_evt >= 0) ? (5'd1 << m_evt) : 5'd0;
        return {g, (m_own >= 0), ix, e};
    endfunction

    function automatic logic [13:0] dvec();
        return {grant, grant_valid, grant_idx, timeout_evt};
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic set_hdr(input int p, input int len);
        flit_id[p*FW +: FW] = FW'(HID);
        length[p*LW +: LW]  = LW'(len);
    endtask

    task automatic set_hdr4(input int p, input int len);
        flit4[p*FW +: FW] = FW'(HID);
        len4[p*4 +: 4]    = 4'(len);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = '0; flit_id = '0; length = '0;
        req4 = '0; flit4 = '0; len4 = '0;
        model_reset();
        #12;
        n_chk++;
        if (dvec() !== 14'd0) begin
            n_fail++;
            $display("FAIL reset_state got=%h exp=0", dvec());
        end
        rst = 1'b0;
        req = 5'b00001;
        repeat (3) begin
            tick();
            n_chk++;
            if (dvec() !== mvec()) begin
                n_fail++;
                $display("FAIL reset_pre got=%h exp=%h",
                         dvec(), mvec());
            end
        end
        #3 rst = 1'b1;
        #1;
        n_chk++;
        if (grant !== 5'd0 || timeout_evt !== 5'd0
            || grant_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_async got=%h exp=0", dvec());
        end
        model_reset();
        req = 5'b00101;
        #2 rst = 1'b0;
        tick();
        n_chk++;
        if (grant !== 5'b00001 || dvec() !== mvec()) begin
            n_fail++;
            $display("FAIL reset_first got=%h exp=%h",
                     dvec(), mvec());
        end
    endtask

    task automatic test_timeout_hold();
        int held;
        bit evt_ok;
        bit seen4;
        held = 0; evt_ok = 1'b0; seen4 = 1'b0;
        req = '0;
        tick();
        set_hdr(2, 4);
        tick();
        flit_id = '0;
        req = 5'b10100;
        for (int c = 0; c < 8; c++) begin
            tick();
            n_chk++;
            if (dvec() !== mvec()) begin
                n_fail++;
                $display("FAIL hold_cyc%0d got=%h exp=%h",
                         c, dvec(), mvec());
            end
            if (grant == 5'b00100) held++;
            if (grant == 5'b10000 && !seen4) begin
                seen4 = 1'b1;
                evt_ok = (timeout_evt == 5'b00100);
            end
        end
        n_chk++;
        if (held !== 4 || !evt_ok) begin
            n_fail++;
            $display("FAIL hold_len got=%0d evt=%0b exp=4 evt=1",
                     held, evt_ok);
        end
        req = '0;
        tick();
    endtask

    task automatic test_rotation();
        int e;
        logic [4:0] eg;
        logic [4:0] ee;
        for (int i = 0; i < NP; i++) set_hdr(i, 1);
        tick();
        flit_id = '0;
        req = 5'b11111;
        for (int k = 0; k < 6; k++) begin
            tick();
            e  = k % NP;
            eg = 5'd1 << e;
            ee = (k == 0) ? 5'd0 : (5'd1 << ((k - 1) % NP));
            n_chk++;
            if ({grant, timeout_evt} !== {eg, ee}) begin
                n_fail++;
                $display("FAIL rot_k%0d got=%b/%b exp=%b/%b",
                         k, grant, timeout_evt, eg, ee);
            end
            n_chk++;
            if (dvec() !== mvec()) begin
                n_fail++;
                $display("FAIL rot_model got=%h exp=%h",
                         dvec(), mvec());
            end
        end
        req = '0;
        tick();
    endtask

    task automatic test_sole_expired();
        logic [4:0] eg [6];
        logic [4:0] ee [6];
        eg = '{5'b01000, 5'b01000, 5'b00000,
               5'b01000, 5'b01000, 5'b00000};
        ee = '{5'b00000, 5'b00000, 5'b01000,
               5'b00000, 5'b00000, 5'b01000};
        set_hdr(3, 2);
        tick();
        flit_id = '0;
        req = 5'b01000;
        for (int k = 0; k < 6; k++) begin
            tick();
            n_chk++;
            if (grant !== eg[k] || timeout_evt !== ee[k]
                || dvec() !== mvec()) begin
                n_fail++;
                $display("FAIL sole_k%0d got=%b/%b exp=%b/%b",
                         k, grant, timeout_evt, eg[k], ee[k]);
            end
        end
        req = '0;
        tick();
    endtask

    task automatic test_unlimited();
        int held;
        held = 0;
        set_hdr(1, 0);
        tick();
        flit_id = '0;
        req = 5'b00010;
        repeat (100) begin
            tick();
            if (grant == 5'b00010 && timeout_evt == 5'd0)
                held++;
        end
        n_chk++;
        if (held !== 100) begin
            n_fail++;
            $display("FAIL unlim_held got=%0d exp=100", held);
        end
        req = '0;
        tick();
        set_hdr(1, 50);
        tick();
        flit_id = '0;
        req = 5'b00010;
        repeat (10) tick();
        n_chk++;
        if (grant !== 5'b00010 || dvec() !== mvec()) begin
            n_fail++;
            $display("FAIL early_hold got=%h exp=%h",
                     dvec(), mvec());
        end
        req = '0;
        tick();
        n_chk++;
        if (grant !== 5'd0 || timeout_evt !== 5'd0
            || dvec() !== mvec()) begin
            n_fail++;
            $display("FAIL early_rel got=%h exp=0", dvec());
        end
    endtask

    task automatic test_limit_change();
        set_hdr(0, 20);
        tick();
        flit_id = '0;
        req = 5'b00001;
        repeat (7) tick();
        set_hdr(0, 3);
        tick();
        n_chk++;
        if (grant !== 5'b00001 || dvec() !== mvec()) begin
            n_fail++;
            $display("FAIL lchg_hold got=%h exp=%h",
                     dvec(), mvec());
        end
        flit_id = '0;
        tick();
        n_chk++;
        if (grant !== 5'd0 || timeout_evt !== 5'b00001
            || dvec() !== mvec()) begin
            n_fail++;
            $display("FAIL lchg_exp got=%b/%b exp=00000/00001",
                     grant, timeout_evt);
        end
        req = '0;
        tick();
    endtask

    task automatic test_saturation();
        int held;
        held = 0;
        set_hdr4(0, 15);
        tick();
        flit4 = '0;
        req4 = 5'b00001;
        for (int k = 0; k < 16; k++) begin
            tick();
            if (grant4 == 5'b00001) held++;
        end
        n_chk++;
        if (held !== 15 || grant4 !== 5'd0
            || evt4 !== 5'b00001) begin
            n_fail++;
            $display("FAIL sat_lim15 got=%0d/%b exp=15/00001",
                     held, evt4);
        end
        req4 = '0;
        tick();
        set_hdr4(0, 0);
        tick();
        flit4 = '0;
        req4 = 5'b00001;
        held = 0;
        repeat (20) begin
            tick();
            if (grant4 == 5'b00001) held++;
        end
        n_chk++;
        if (held !== 20) begin
            n_fail++;
            $display("FAIL sat_unlim got=%0d exp=20", held);
        end
        set_hdr4(0, 15);
        tick();
        flit4 = '0;
        n_chk++;
        if (grant4 !== 5'b00001) begin
            n_fail++;
            $display("FAIL sat_pre got=%b exp=00001", grant4);
        end
        tick();
        n_chk++;
        if (grant4 !== 5'd0 || evt4 !== 5'b00001) begin
            n_fail++;
            $display("FAIL sat_edge got=%b/%b exp=00000/00001",
                     grant4, evt4);
        end
        req4 = '0;
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 500; c++) begin
            req = 5'($urandom);
            for (int i = 0; i < NP; i++) begin
                flit_id[i*FW +: FW] = FW'($urandom_range(0, 7));
                length[i*LW +: LW]  = LW'($urandom_range(0, 6));
            end
            tick();
            n_chk++;
            if (dvec() !== mvec()) begin
                n_fail++;
                $display("FAIL rand_c%0d got=%h exp=%h",
                         c, dvec(), mvec());
            end
            n_chk++;
            if ($countones(grant) > 1
                || $countones(timeout_evt) > 1
                || grant_valid !== (grant != 5'd0)) begin
                n_fail++;
                $display("FAIL rand_inv got=%b/%b exp=onehot",
                         grant, timeout_evt);
            end
        end
        req = '0;
        flit_id = '0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_timeout_hold();
        test_rotation();
        test_sole_expired();
        test_unlimited();
        test_limit_change();
        test_saturation();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
